// File: rtl/fetch_pkg.sv
// Shared types and constants for the LEGv8 instruction-fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    HALT  = 2'd3
  } fetch_state_t;

  localparam int PC_INCR    = 4;
  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 21;

endpackage : fetch_pkg

// File: rtl/next_pc.sv
// Next-PC computation: sequential increment or word-scaled branch target.
// The result also yields a misaligned flag used to trap on a bad target.
module next_pc
  import fetch_pkg::*;
#(
  parameter int ADDR_W = 64
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] sign_ext_imm,
  input  logic              branch,
  input  logic              uncond_branch,
  input  logic              alu_zero,
  output logic [ADDR_W-1:0] next_addr,
  output logic              misaligned
);

  logic take;

  // Select branch target or fall-through; additions wrap modulo 2^ADDR_W.
  always_comb begin
    take       = uncond_branch | (branch & alu_zero);
    next_addr  = take ? (pc + (sign_ext_imm << 2)) : (pc + ADDR_W'(PC_INCR));
    misaligned = (next_addr[1:0] != 2'b00);
  end

endmodule : next_pc

// File: rtl/instruction_fetch.sv
// LEGv8 fetch stage: PC register, req/ack instruction fetch, branch-aware
// PC update on retire, sticky misaligned-PC fault and retire counter.
//
// Handshake: imem_req is a Moore output held high for the whole FETCH state;
// an instruction transfers on a rising edge where imem_req and imem_ack are
// both 1. imem_ack is ignored outside FETCH, and retire is ignored outside HOLD.
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter int ADDR_W  = 64,
  parameter int INSTR_W = 32,
  parameter int CNT_W   = 32
) (
  input  logic               CLK,
  input  logic               resetl,
  input  logic [ADDR_W-1:0]  startpc,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instruction,
  output logic [10:0]        opcode,
  output logic [ADDR_W-1:0]  pc,
  input  logic               retire,
  input  logic               branch,
  input  logic               uncond_branch,
  input  logic               alu_zero,
  input  logic [ADDR_W-1:0]  sign_ext_imm,
  output logic               fault,
  output logic [CNT_W-1:0]   retired_count,
  output fetch_state_t       dbg_state
);

  fetch_state_t      state, state_next;
  logic [ADDR_W-1:0] npc;
  logic              npc_misaligned;
  logic              boot_misaligned;

  next_pc #(.ADDR_W(ADDR_W)) u_next_pc (
    .pc            (pc),
    .sign_ext_imm  (sign_ext_imm),
    .branch        (branch),
    .uncond_branch (uncond_branch),
    .alu_zero      (alu_zero),
    .next_addr     (npc),
    .misaligned    (npc_misaligned)
  );

  assign boot_misaligned = (startpc[1:0] != 2'b00);
  assign imem_addr       = pc;
  assign opcode          = instruction[OPCODE_MSB:OPCODE_LSB];
  assign dbg_state       = state;

  // State register; reset aborts any fetch or hold immediately.
  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) state <= BOOT;
    else         state <= state_next;
  end

  // Next-state and Moore outputs.
  always_comb begin
    state_next  = state;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    case (state)
      BOOT:  state_next = boot_misaligned ? HALT : FETCH;
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) state_next = HOLD;
      end
      HOLD: begin
        instr_valid = 1'b1;
        if (retire) state_next = npc_misaligned ? HALT : FETCH;
      end
      HALT:    state_next = HALT;
      default: state_next = BOOT;
    endcase
  end

  // PC, instruction register, fault and retire counter.
  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      pc            <= '0;
      instruction   <= '0;
      fault         <= 1'b0;
      retired_count <= '0;
    end else begin
      case (state)
        BOOT: begin
          pc <= startpc;
          if (boot_misaligned) fault <= 1'b1;
        end
        FETCH: begin
          if (imem_ack) instruction <= imem_rdata;
        end
        HOLD: begin
          if (retire) begin
            retired_count <= retired_count + CNT_W'(1);
            if (npc_misaligned) fault <= 1'b1;
            else                pc    <= npc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule : instruction_fetch

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch.
module tb_instruction_fetch;
  import fetch_pkg::*;

  localparam int ADDR_W  = 64;
  localparam int INSTR_W = 32;
  localparam int CNT_W   = 32;

  logic               CLK = 1'b0;
  logic               resetl;
  logic [ADDR_W-1:0]  startpc;
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;
  logic               instr_valid;
  logic [INSTR_W-1:0] instruction;
  logic [10:0]        opcode;
  logic [ADDR_W-1:0]  pc;
  logic               retire;
  logic               branch;
  logic               uncond_branch;
  logic               alu_zero;
  logic [ADDR_W-1:0]  sign_ext_imm;
  logic               fault;
  logic [CNT_W-1:0]   retired_count;
  fetch_state_t       dbg_state;

  int tests_run    = 0;
  int tests_failed = 0;
  logic [INSTR_W-1:0] exp_q[$];

  instruction_fetch #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .CNT_W(CNT_W)) dut (
    .CLK           (CLK),
    .resetl        (resetl),
    .startpc       (startpc),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .instr_valid   (instr_valid),
    .instruction   (instruction),
    .opcode        (opcode),
    .pc            (pc),
    .retire        (retire),
    .branch        (branch),
    .uncond_branch (uncond_branch),
    .alu_zero      (alu_zero),
    .sign_ext_imm  (sign_ext_imm),
    .fault         (fault),
    .retired_count (retired_count),
    .dbg_state     (dbg_state)
  );

  // Clock and reset
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Hold reset for two cycles, then release so the next edge samples startpc.
  task automatic apply_reset(input logic [ADDR_W-1:0] spc);
    resetl        = 1'b0;
    startpc       = spc;
    imem_ack      = 1'b0;
    imem_rdata    = '0;
    retire        = 1'b0;
    branch        = 1'b0;
    uncond_branch = 1'b0;
    alu_zero      = 1'b0;
    sign_ext_imm  = '0;
    exp_q.delete();
    tick();
    tick();
    resetl = 1'b1;
  endtask

  // Driver: ack after 'delay' idle cycles; scoreboard pops when instr_valid rises.
  task automatic fetch_instr(input logic [INSTR_W-1:0] data, input int delay);
    int waited;
    logic [INSTR_W-1:0] exp;
    imem_ack = 1'b0;
    for (int i = 0; i < delay; i++) tick();
    imem_ack   = 1'b1;
    imem_rdata = data;
    exp_q.push_back(data);
    waited = 0;
    do begin
      tick();
      waited++;
    end while (!instr_valid && waited < 8);
    imem_ack   = 1'b0;
    imem_rdata = $urandom();
    tests_run++;
    if (instr_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL fetch_timeout: instr_valid=%b after %0d cycles, required 1", instr_valid, waited);
      void'(exp_q.pop_front());
    end else begin
      exp = exp_q.pop_front();
      tests_run++;
      if (waited !== 1) begin
        tests_failed++;
        $display("FAIL fetch_latency: %0d cycles after ack, required 1", waited);
      end
      tests_run++;
      if (instruction !== exp) begin
        tests_failed++;
        $display("FAIL fetch_instr: instruction=%h, required %h", instruction, exp);
      end
      tests_run++;
      if (opcode !== exp[31:21]) begin
        tests_failed++;
        $display("FAIL fetch_opcode: opcode=%h, required %h", opcode, exp[31:21]);
      end
    end
  endtask

  // Driver: one retire edge with the given branch controls.
  task automatic retire_instr(input logic br, input logic ub, input logic z,
                              input logic [ADDR_W-1:0] imm);
    retire        = 1'b1;
    branch        = br;
    uncond_branch = ub;
    alu_zero      = z;
    sign_ext_imm  = imm;
    tick();
    retire        = 1'b0;
    branch        = 1'b0;
    uncond_branch = 1'b0;
    alu_zero      = 1'b0;
    sign_ext_imm  = '0;
  endtask

  task automatic test_reset();
    resetl = 1'b0;
    startpc = 64'h1000;
    imem_ack = 1'b0; imem_rdata = '0; retire = 1'b0;
    branch = 1'b0; uncond_branch = 1'b0; alu_zero = 1'b0; sign_ext_imm = '0;
    tick();
    tests_run++;
    if ({imem_req, instr_valid, fault} !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset_flags: req/valid/fault=%b%b%b, required 000", imem_req, instr_valid, fault);
    end
    tests_run++;
    if (pc !== '0 || imem_addr !== '0 || instruction !== '0 || retired_count !== '0) begin
      tests_failed++;
      $display("FAIL reset_regs: pc=%h addr=%h instr=%h cnt=%0d, required all 0",
               pc, imem_addr, instruction, retired_count);
    end
    tests_run++;
    if (dbg_state !== BOOT) begin
      tests_failed++;
      $display("FAIL reset_state: state=%0d, required %0d", dbg_state, BOOT);
    end
  endtask

  task automatic test_boot_fetch();
    apply_reset(64'h1000);
    tick();
    tests_run++;
    if (imem_req !== 1'b1 || imem_addr !== 64'h1000) begin
      tests_failed++;
      $display("FAIL boot_req: req=%b addr=%h, required 1 / 1000", imem_req, imem_addr);
    end
    // Delayed ack: request must stay up and instr_valid low while waiting.
    imem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests_run++;
      if (imem_req !== 1'b1 || instr_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL boot_wait: req=%b valid=%b, required 1 / 0", imem_req, instr_valid);
      end
    end
    fetch_instr(32'h8B02_0020, 0);
    tests_run++;
    if (imem_req !== 1'b0 || pc !== 64'h1000) begin
      tests_failed++;
      $display("FAIL boot_hold: req=%b pc=%h, required 0 / 1000", imem_req, pc);
    end
  endtask

  task automatic test_sequential();
    // Still in HOLD from the previous test; stay there two cycles first.
    imem_ack = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    tick();
    tick();
    imem_ack = 1'b0;
    tests_run++;
    if (instr_valid !== 1'b1 || instruction !== 32'h8B02_0020 || pc !== 64'h1000) begin
      tests_failed++;
      $display("FAIL hold_stable: valid=%b instr=%h pc=%h, required 1 / 8b020020 / 1000",
               instr_valid, instruction, pc);
    end
    retire_instr(1'b0, 1'b0, 1'b1, 64'h10);
    tests_run++;
    if (pc !== 64'h1004 || retired_count !== 32'd1 || imem_req !== 1'b1 || instr_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL seq_retire: pc=%h cnt=%0d req=%b valid=%b, required 1004 / 1 / 1 / 0",
               pc, retired_count, imem_req, instr_valid);
    end
  endtask

  task automatic test_cbz();
    fetch_instr(32'hB400_0040, 1);
    retire_instr(1'b0, 1'b0, 1'b0, '0);
    tests_run++;
    if (pc !== 64'h1008) begin
      tests_failed++;
      $display("FAIL cbz_setup: pc=%h, required 1008", pc);
    end
    fetch_instr(32'hB4FF_FFC0, 0);
    retire_instr(1'b1, 1'b0, 1'b1, -64'sd2);
    tests_run++;
    if (pc !== 64'h1000 || retired_count !== 32'd3 || fault !== 1'b0) begin
      tests_failed++;
      $display("FAIL cbz_taken: pc=%h cnt=%0d fault=%b, required 1000 / 3 / 0", pc, retired_count, fault);
    end
    fetch_instr(32'h1111_1111, 0);
    retire_instr(1'b0, 1'b0, 1'b1, 64'h40);
    fetch_instr(32'h2222_2222, 2);
    retire_instr(1'b0, 1'b0, 1'b0, 64'h40);
    fetch_instr(32'hB4FF_FFC0, 0);
    retire_instr(1'b1, 1'b0, 1'b0, -64'sd2);
    tests_run++;
    if (pc !== 64'h100C || retired_count !== 32'd6) begin
      tests_failed++;
      $display("FAIL cbz_not_taken: pc=%h cnt=%0d, required 100c / 6", pc, retired_count);
    end
  endtask

  task automatic test_uncond_wrap();
    apply_reset(64'hFFFF_FFFF_FFFF_FFFC);
    tick();
    fetch_instr(32'h1400_0001, 0);
    retire_instr(1'b0, 1'b1, 1'b0, 64'h1);
    tests_run++;
    if (pc !== '0 || fault !== 1'b0 || retired_count !== 32'd1 || dbg_state !== FETCH) begin
      tests_failed++;
      $display("FAIL uncond_wrap: pc=%h fault=%b cnt=%0d state=%0d, required 0 / 0 / 1 / %0d",
               pc, fault, retired_count, dbg_state, FETCH);
    end
  endtask

  // Random fetch delays and branch controls against a reference PC model.
  task automatic test_back_to_back();
    logic [ADDR_W-1:0] model_pc;
    logic [CNT_W-1:0]  model_cnt;
    logic br, ub, z;
    logic [ADDR_W-1:0] imm;
    apply_reset(64'h4000);
    tick();
    model_pc  = 64'h4000;
    model_cnt = '0;
    for (int n = 0; n < 10; n++) begin
      fetch_instr($urandom(), $urandom_range(0, 3));
      br  = 1'($urandom_range(0, 1));
      ub  = ($urandom_range(0, 3) == 0);
      z   = 1'($urandom_range(0, 1));
      imm = ADDR_W'($signed($urandom_range(0, 64)) - 32);
      retire_instr(br, ub, z, imm);
      if (ub || (br && z)) model_pc = model_pc + {imm[ADDR_W-3:0], 2'b00};
      else                 model_pc = model_pc + 64'd4;
      model_cnt = model_cnt + 1;
      tests_run++;
      if (pc !== model_pc || retired_count !== model_cnt) begin
        tests_failed++;
        $display("FAIL b2b_%0d: pc=%h cnt=%0d, required %h / %0d", n, pc, retired_count, model_pc, model_cnt);
      end
    end
  endtask

  task automatic test_misalign();
    int req_seen;
    apply_reset(64'h1002);
    req_seen = 0;
    if (imem_req) req_seen++;
    tick();
    tests_run++;
    if (dbg_state !== HALT || fault !== 1'b1 || pc !== 64'h1002) begin
      tests_failed++;
      $display("FAIL misalign_halt: state=%0d fault=%b pc=%h, required %0d / 1 / 1002",
               dbg_state, fault, pc, HALT);
    end
    imem_ack = 1'b1; imem_rdata = 32'hCAFE_F00D;
    retire = 1'b1; uncond_branch = 1'b1; sign_ext_imm = 64'h8;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (imem_req) req_seen++;
    end
    imem_ack = 1'b0; retire = 1'b0; uncond_branch = 1'b0; sign_ext_imm = '0;
    tests_run++;
    if (req_seen !== 0) begin
      tests_failed++;
      $display("FAIL misalign_req: imem_req seen %0d times, required 0", req_seen);
    end
    tests_run++;
    if (pc !== 64'h1002 || retired_count !== '0 || instruction !== '0 || instr_valid !== 1'b0 || fault !== 1'b1) begin
      tests_failed++;
      $display("FAIL misalign_stuck: pc=%h cnt=%0d instr=%h valid=%b fault=%b, required 1002 / 0 / 0 / 0 / 1",
               pc, retired_count, instruction, instr_valid, fault);
    end
  endtask

  task automatic test_reset_mid_fetch();
    apply_reset(64'h2000);
    tick();
    fetch_instr(32'h9100_0421, 0);
    retire_instr(1'b0, 1'b0, 1'b0, '0);
    // Retire while in FETCH must be ignored.
    retire_instr(1'b0, 1'b1, 1'b0, 64'h100);
    tests_run++;
    if (pc !== 64'h2004 || retired_count !== 32'd1 || imem_req !== 1'b1) begin
      tests_failed++;
      $display("FAIL retire_in_fetch: pc=%h cnt=%0d req=%b, required 2004 / 1 / 1", pc, retired_count, imem_req);
    end
    #2;
    resetl = 1'b0;
    #1;
    tests_run++;
    if (imem_req !== 1'b0 || pc !== '0 || retired_count !== '0 || instruction !== '0) begin
      tests_failed++;
      $display("FAIL reset_mid_fetch: req=%b pc=%h cnt=%0d instr=%h, required 0 / 0 / 0 / 0",
               imem_req, pc, retired_count, instruction);
    end
    tick();
    resetl = 1'b1;
  endtask

  initial begin
    test_reset();
    test_boot_fetch();
    test_sequential();
    test_cbz();
    test_uncond_wrap();
    test_back_to_back();
    test_misalign();
    test_reset_mid_fetch();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Hard bound on simulation time.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule : tb_instruction_fetch

// File: doc/instruction_fetch.md
# instruction_fetch

Upstream fetch stage of the LEGv8 processor: holds the program counter, fetches 32-bit instructions from instruction memory over a req/ack handshake, presents the instruction and its 11-bit opcode field to the main control decoder and datapath, and computes the next PC from the branch controls returned when the instruction retires. It also detects misaligned PCs, halting with a sticky fault, and counts retired instructions.

## Interface
- `ADDR_W`, 64, PC / instruction-memory address width
- `INSTR_W`, 32, instruction width
- `CNT_W`, 32, retired-instruction counter width
- `CLK`  in  1  clock; all state changes on rising edge
- `resetl`  in  1  asynchronous, active-low reset
- `startpc`  in  ADDR_W  boot address, sampled on the first edge after reset release
- `imem_req`  out  1  fetch request
- `imem_addr`  out  ADDR_W  fetch address, equal to `pc`
- `imem_ack`  in  1  instruction-memory data valid
- `imem_rdata`  in  INSTR_W  fetched instruction
- `instr_valid`  out  1  `instruction`/`opcode` hold a live instruction
- `instruction`  out  INSTR_W  instruction register
- `opcode`  out  11  `instruction[31:21]`, feeds control decoder
- `pc`  out  ADDR_W  address of current instruction
- `retire`  in  1  datapath has finished the current instruction
- `branch`  in  1  conditional-branch control for the retiring instruction
- `uncond_branch`  in  1  unconditional-branch control
- `alu_zero`  in  1  ALU zero flag
- `sign_ext_imm`  in  ADDR_W  sign-extended branch offset, in words
- `fault`  out  1  sticky misaligned-PC fault
- `retired_count`  out  CNT_W  number of retired instructions

## Operation
- States: BOOT, FETCH, HOLD, HALT.
- Reset (asynchronous, any state): state=BOOT, `pc`=0, `instruction`=0, `retired_count`=0, `fault`=0. All outputs are 0 during reset.
- BOOT: next edge loads `pc`=`startpc`. If `startpc[1:0]`≠0, go to HALT with `fault`=1; otherwise go to FETCH.
- FETCH: `imem_req`=1, `imem_addr`=`pc`. `imem_req` is a Moore output and stays high until ack. On an edge with `imem_ack`=1, capture `imem_rdata` into `instruction` and go to HOLD. `imem_ack` is ignored in all other states.
- HOLD: `instr_valid`=1 and `imem_req`=0. `branch`, `uncond_branch`, `alu_zero` and `sign_ext_imm` are sampled only on an edge where `retire`=1. On that edge:
  - next = `pc` + (`sign_ext_imm` << 2) if `uncond_branch` | (`branch` & `alu_zero`), else `pc` + 4.
  - Arithmetic is modulo 2^ADDR_W; wrap-around is legal and not flagged.
  - `retired_count` increments, wrapping at 2^CNT_W.
  - If next[1:0]≠0: `pc` is not updated, state goes to HALT, `fault`=1. Otherwise `pc`=next and state goes to FETCH.
- `retire` outside HOLD is ignored.
- HALT: all outputs hold and `imem_req`=0. Only reset exits HALT.
- `instr_valid`=1 only in HOLD.

## Timing
- Minimum 2 cycles per instruction with a same-cycle ack: FETCH (req+ack), then HOLD (retire).
- Fetch latency = cycles until `imem_ack` + 1; HOLD persists until `retire`.
- `instruction`, `opcode` and `pc` are stable throughout HOLD. `opcode` is combinational from `instruction`.
- `fault` and `retired_count` are registered and update on the retiring edge.
- Reset asserted mid-fetch or mid-HOLD aborts immediately. No retire is counted and the request drops combinationally.

## Structure
- Shared package `fetch_pkg`:
  - state enum {BOOT, FETCH, HOLD, HALT}
  - `PC_INCR`=4
  - `OPCODE_MSB`=31, `OPCODE_LSB`=21
- Sub-module `next_pc`: combinational next-address adder/mux with inputs pc, sign_ext_imm, branch, uncond_branch, alu_zero; it also drives a misaligned flag.

## Test plan
- Boot and fetch: reset, `startpc`=0x1000, ack in FETCH → `imem_addr`=0x1000. Ack delayed 3 cycles → `instr_valid` rises one edge after ack with `instruction`=`imem_rdata`.
- Sequential retire: retire with no branch at `pc`=0x1000 → `pc`=0x1004, `retired_count`=1.
- CBZ taken/not taken: `branch`=1, `alu_zero`=1, imm=−2 at 0x1008 → `pc`=0x1000. Same with `alu_zero`=0 → 0x100C.
- Unconditional B with imm=1 at 0xFFFF_FFFF_FFFF_FFFC → `pc`=0x0 (wrap), no fault.
- Misalignment: `startpc`=0x1002 → HALT with `fault`=1, `imem_req` never asserted. Then ack and retire → no change.
- Reset mid-FETCH with `imem_req`=1: `resetl` low → `imem_req`=0, `pc`=0, `retired_count`=0 immediately. Retire in FETCH → ignored.
